bus_cycle_initiator: RTL and testbench
======================================

// Module: bus_cycle_initiator
// PURPOSE
//  8088 minimum-mode bus master. Converts single-beat requests (mem/io rd/wr, interrupt acknowledge)
//  into T1-T2-T3-(Tw)*-T4 cycles on ALE/RD_N/WR_N/IO_OR_M/DT_OR_R/DEN_N/INTA_N. Honours RDY
//  wait states. Initiating end of the chipset bus: drives cycles into the chipset for bench/DMA masters.
// PARAMETERS
//  MAX_WAIT_STATES   255  Tw count after which the cycle is force-ended with rsp_error (1..255)
//  INTA_IDLE_STATES  2    idle T-states between first and second INTA cycle (0..3)
// PORTS
//  clock              in   1   system clock
//  reset_n            in   1   synchronous, active-low reset
//  cpu_clock_posedge  in   1   T-state advance enable
//  cpu_clock_negedge  in   1   RDY sample enable
//  req_valid          in   1   request present
//  req_ready          out  1   request accepted when req_valid & req_ready & cpu_clock_posedge
//  req_type           in   3   bus_cycle_t: MEM_RD, MEM_WR, IO_RD, IO_WR, INTA
//  req_address        in   20  cycle address (IO: [15:0] used, [19:16] driven 0)
//  req_data           in   8   write data
//  rsp_valid          out  1   one-clock pulse: cycle done (write, read, or INTA2)
//  rsp_data           out  8   read data / interrupt vector; held until next rsp_valid
//  rsp_error          out  1   valid with rsp_valid; wait-state timeout
//  ADDRESS            out  20  bus address, driven T1..T4, else 0
//  DATA_OUT           out  8   write data, driven T2..T4 of writes, else 0
//  DATA_IN            in   8   read data / vector
//  RDY                in   1   ready from chipset
//  ALE RD_N WR_N IO_OR_M DT_OR_R DEN_N INTA_N  out 1 each  8088 min-mode strobes
//  busy               out  1   state != IDLE
// BEHAVIOUR
//  Reset (reset_n=0 sampled): state IDLE; ALE=0, RD_N=WR_N=INTA_N=DEN_N=1, IO_OR_M=0, DT_OR_R=1,
//   ADDRESS=0, DATA_OUT=0, rsp_valid=0, rsp_error=0, rsp_data=0. Reset mid-cycle: strobes
//   deasserted that clock, no rsp_valid, request lost.
//  All state changes on clocks with cpu_clock_posedge=1; other clocks hold every output.
//  req_ready = (state==IDLE) & cpu_clock_posedge & reset_n; acceptance latches type/address/data, ->T1.
//  T1: ALE=1; ADDRESS, IO_OR_M (1 for IO and INTA), DT_OR_R (0 for reads/INTA, 1 for writes) set.
//  T2: ALE=0; RD_N=0 (rd), WR_N=0 (wr), INTA_N=0 (INTA); DEN_N=0; DATA_OUT driven on writes.
//  T3/Tw: strobes held. rdy_q <= RDY on each cpu_clock_negedge; at next posedge: rdy_q=1 -> T4,
//   rdy_q=0 -> Tw (wait counter +1). rdy_q cleared on entering T2.
//  Timeout: posedge in Tw with count==MAX_WAIT_STATES -> T4, rsp_error=1, rsp_data=8'hFF.
//  T3/Tw->T4 transition: read/INTA data captured from DATA_IN; RD_N/WR_N/INTA_N/DEN_N -> 1;
//   rsp_valid pulses that clock (not for INTA1).
//  T4 -> IDLE; DT_OR_R returns 1, IO_OR_M 0, ADDRESS/DATA_OUT 0. Min request spacing 5 T-states.
//  INTA: INTA1 cycle (data discarded, no rsp), INTA_IDLE_STATES Ti states (all strobes inactive,
//   req_ready=0), INTA2 cycle; vector from INTA2 returned. Timeout in INTA1 aborts INTA2, rsp_error=1.
//  Strobes registered, glitch-free; RD_N, WR_N, INTA_N never low simultaneously.
// STRUCTURE
//  Package chipset_bus_pkg: bus_cycle_t enum, bus_state_t {IDLE,T1,T2,T3,TW,T4,TI}, MAX width consts.
//  Sub-module bus_wait_counter: clear/increment/terminal-count flag for Tw and Ti counting.
// TESTING
//  MEM_RD 0xF0000, RDY=1, DATA_IN=0x5A -> ALE one T-state, RD_N low T2-T3, rsp_data=0x5A, error=0.
//  IO_WR 0x0021 data 0xFE -> IO_OR_M=1, DT_OR_R=1, WR_N low 2 T-states, DATA_OUT=0xFE, rsp_valid.
//  MEM_RD with RDY low 3 negedges -> exactly 3 Tw, RD_N low 5 T-states, data captured at T4.
//  INTA, DATA_IN=0x08 on INTA2 -> two INTA_N pulses separated by 2 Ti, single rsp, rsp_data=0x08.
//  RDY stuck 0, MAX_WAIT_STATES=4 -> 4 Tw, rsp_error=1, rsp_data=0xFF, returns IDLE.
//  reset_n=0 in T2 of a write -> WR_N/DEN_N high next clock, no rsp_valid, req_ready after release.

Source files
------------

// File: rtl/chipset_bus_pkg.sv
// Shared definitions for the chipset bus initiator.
// Defines the request cycle type, the T-state encoding, the bus and counter
// widths, and small helpers that classify a cycle type.
package chipset_bus_pkg;

  localparam int ADDR_W     = 20;
  localparam int DATA_W     = 8;
  localparam int WAIT_CNT_W = 8;

  typedef enum logic [2:0] {
    MEM_RD = 3'd0,
    MEM_WR = 3'd1,
    IO_RD  = 3'd2,
    IO_WR  = 3'd3,
    INTA   = 3'd4
  } bus_cycle_t;

  typedef enum logic [2:0] {IDLE, T1, T2, T3, TW, T4, TI} bus_state_t;

  function automatic logic cycle_is_write(input bus_cycle_t t);
    return (t == MEM_WR) || (t == IO_WR);
  endfunction

  function automatic logic cycle_is_read(input bus_cycle_t t);
    return (t == MEM_RD) || (t == IO_RD);
  endfunction

  // IO_OR_M is high for port cycles and for interrupt acknowledge.
  function automatic logic cycle_is_io(input bus_cycle_t t);
    return (t == IO_RD) || (t == IO_WR) || (t == INTA);
  endfunction

  // Port cycles only carry a 16-bit address.
  function automatic logic cycle_is_port(input bus_cycle_t t);
    return (t == IO_RD) || (t == IO_WR);
  endfunction

endpackage

// File: rtl/bus_wait_counter.sv
// Wait/idle T-state counter.
// Ports:
//   clock, reset_n : clock and synchronous active-low reset
//   clr            : return count to zero (wins over inc)
//   inc            : count up by one, saturating
//   terminal       : value at which tc is flagged
//   tc             : count equals terminal
module bus_wait_counter
  import chipset_bus_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  clr,
  input  logic                  inc,
  input  logic [WAIT_CNT_W-1:0] terminal,
  output logic                  tc
);

  logic [WAIT_CNT_W-1:0] count_q;
  logic [WAIT_CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + WAIT_CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == terminal);

endmodule

// File: rtl/bus_cycle_initiator.sv
// 8088 minimum-mode bus master.
// Turns single-beat requests (memory/IO read/write, interrupt acknowledge)
// into T1-T2-T3-(Tw)*-T4 cycles with registered min-mode strobes.
// Ports:
//   clock, reset_n            : clock, synchronous active-low reset
//   cpu_clock_posedge/negedge : T-state advance / RDY sample enables
//   req_*                     : request handshake, type, address, write data
//   rsp_*                     : completion pulse, read data/vector, timeout flag
//   ADDRESS, DATA_OUT, DATA_IN: bus address and data
//   RDY                       : chipset ready
//   ALE..INTA_N               : 8088 min-mode strobes
//   busy                      : cycle in progress
module bus_cycle_initiator
  import chipset_bus_pkg::*;
#(
  parameter int MAX_WAIT_STATES  = 255,
  parameter int INTA_IDLE_STATES = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cpu_clock_posedge,
  input  logic              cpu_clock_negedge,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_type,
  input  logic [ADDR_W-1:0] req_address,
  input  logic [DATA_W-1:0] req_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_error,
  output logic [ADDR_W-1:0] ADDRESS,
  output logic [DATA_W-1:0] DATA_OUT,
  input  logic [DATA_W-1:0] DATA_IN,
  input  logic              RDY,
  output logic              ALE,
  output logic              RD_N,
  output logic              WR_N,
  output logic              IO_OR_M,
  output logic              DT_OR_R,
  output logic              DEN_N,
  output logic              INTA_N,
  output logic              busy
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_TERM = WAIT_CNT_W'(MAX_WAIT_STATES);
  localparam logic [WAIT_CNT_W-1:0] IDLE_TERM = WAIT_CNT_W'(INTA_IDLE_STATES);

  bus_state_t        state_q, state_d;
  bus_cycle_t        type_q, type_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              inta2_q, inta2_d;      // current cycle is the second INTA
  logic              pending_q, pending_d;  // INTA1 done, INTA2 still owed
  logic              rdy_q, rdy_d;
  logic              ale_q, ale_d, rd_n_q, rd_n_d, wr_n_q, wr_n_d;
  logic              inta_n_q, inta_n_d, den_n_q, den_n_d;
  logic              io_or_m_q, io_or_m_d, dt_or_r_q, dt_or_r_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              rsp_valid_q, rsp_valid_d, rsp_error_q, rsp_error_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

  logic                  cnt_clr, cnt_inc, cnt_tc;
  logic [WAIT_CNT_W-1:0] cnt_term;
  logic                  finish, timeout, enter_t1;

  // One counter serves both Tw (timeout) and Ti (INTA gap) counting.
  assign cnt_term = (state_q == TI) ? IDLE_TERM : WAIT_TERM;

  bus_wait_counter u_wait_counter (
    .clock    (clock),
    .reset_n  (reset_n),
    .clr      (cnt_clr),
    .inc      (cnt_inc),
    .terminal (cnt_term),
    .tc       (cnt_tc)
  );

  assign req_ready = (state_q == IDLE) && cpu_clock_posedge && reset_n;

  always_comb begin
    state_d     = state_q;
    type_d      = type_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    inta2_d     = inta2_q;
    pending_d   = pending_q;
    rdy_d       = rdy_q;
    ale_d       = ale_q;
    rd_n_d      = rd_n_q;
    wr_n_d      = wr_n_q;
    inta_n_d    = inta_n_q;
    den_n_d     = den_n_q;
    io_or_m_d   = io_or_m_q;
    dt_or_r_d   = dt_or_r_q;
    address_d   = address_q;
    data_out_d  = data_out_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_error_d = rsp_error_q;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    finish      = 1'b0;
    timeout     = 1'b0;
    enter_t1    = 1'b0;

    if (cpu_clock_negedge) begin
      rdy_d = RDY;
    end

    if (cpu_clock_posedge) begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            // Undefined type codes degrade to a memory read.
            type_d    = (req_type <= 3'(INTA)) ? bus_cycle_t'(req_type) : MEM_RD;
            addr_d    = cycle_is_port(type_d) ? {4'h0, req_address[15:0]} : req_address;
            wdata_d   = req_data;
            inta2_d   = 1'b0;
            pending_d = 1'b0;
            enter_t1  = 1'b1;
          end
        end
        T1: begin
          state_d  = T2;
          ale_d    = 1'b0;
          rd_n_d   = ~cycle_is_read(type_q);
          wr_n_d   = ~cycle_is_write(type_q);
          inta_n_d = ~(type_q == INTA);
          den_n_d  = 1'b0;
          if (cycle_is_write(type_q)) begin
            data_out_d = wdata_q;
          end
          rdy_d   = 1'b0;  // only RDY seen from T2 onwards may end the cycle
          cnt_clr = 1'b1;
        end
        T2: state_d = T3;
        T3, TW: begin
          // A late RDY wins over the timeout in the same T-state.
          if (rdy_q) begin
            finish = 1'b1;
          end else if ((state_q == TW) && cnt_tc) begin
            finish  = 1'b1;
            timeout = 1'b1;
          end else begin
            state_d = TW;
            cnt_inc = 1'b1;
          end
        end
        T4: begin
          io_or_m_d  = 1'b0;
          dt_or_r_d  = 1'b1;
          address_d  = '0;
          data_out_d = '0;
          if (pending_q) begin
            if (INTA_IDLE_STATES == 0) begin
              enter_t1  = 1'b1;
              pending_d = 1'b0;
              inta2_d   = 1'b1;
            end else begin
              state_d = TI;
              cnt_inc = 1'b1;
            end
          end else begin
            state_d = IDLE;
          end
        end
        TI: begin
          if (cnt_tc) begin
            enter_t1  = 1'b1;
            pending_d = 1'b0;
            inta2_d   = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (finish) begin
      state_d  = T4;
      rd_n_d   = 1'b1;
      wr_n_d   = 1'b1;
      inta_n_d = 1'b1;
      den_n_d  = 1'b1;
      cnt_clr  = 1'b1;
      if (timeout) begin
        // A timeout in INTA1 also abandons INTA2 since pending is never set.
        rsp_valid_d = 1'b1;
        rsp_error_d = 1'b1;
        rsp_data_d  = 8'hFF;
      end else if ((type_q == INTA) && !inta2_q) begin
        pending_d = 1'b1;
      end else begin
        rsp_valid_d = 1'b1;
        rsp_error_d = 1'b0;
        if (!cycle_is_write(type_q)) begin
          rsp_data_d = DATA_IN;
        end
      end
    end

    if (enter_t1) begin
      state_d   = T1;
      ale_d     = 1'b1;
      address_d = addr_d;
      io_or_m_d = cycle_is_io(type_d);
      dt_or_r_d = cycle_is_write(type_d);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      type_q      <= MEM_RD;
      addr_q      <= '0;
      wdata_q     <= '0;
      inta2_q     <= 1'b0;
      pending_q   <= 1'b0;
      rdy_q       <= 1'b0;
      ale_q       <= 1'b0;
      rd_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
      inta_n_q    <= 1'b1;
      den_n_q     <= 1'b1;
      io_or_m_q   <= 1'b0;
      dt_or_r_q   <= 1'b1;
      address_q   <= '0;
      data_out_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      type_q      <= type_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      inta2_q     <= inta2_d;
      pending_q   <= pending_d;
      rdy_q       <= rdy_d;
      ale_q       <= ale_d;
      rd_n_q      <= rd_n_d;
      wr_n_q      <= wr_n_d;
      inta_n_q    <= inta_n_d;
      den_n_q     <= den_n_d;
      io_or_m_q   <= io_or_m_d;
      dt_or_r_q   <= dt_or_r_d;
      address_q   <= address_d;
      data_out_q  <= data_out_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_error = rsp_error_q;
  assign ADDRESS   = address_q;
  assign DATA_OUT  = data_out_q;
  assign ALE       = ale_q;
  assign RD_N      = rd_n_q;
  assign WR_N      = wr_n_q;
  assign INTA_N    = inta_n_q;
  assign DEN_N     = den_n_q;
  assign IO_OR_M   = io_or_m_q;
  assign DT_OR_R   = dt_or_r_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_bus_cycle_initiator.sv
// Directed bench for bus_cycle_initiator: a vector table of whole bus cycles
// with hand-computed strobe counts and responses, plus reset sequences.
module tb_bus_cycle_initiator;
  import chipset_bus_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        cpu_clock_posedge = 1'b0;
  logic        cpu_clock_negedge = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_type = 3'd0;
  logic [19:0] req_address = '0;
  logic [7:0]  req_data = '0;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic        rsp_error;
  logic [19:0] ADDRESS;
  logic [7:0]  DATA_OUT;
  logic [7:0]  DATA_IN = '0;
  logic        RDY = 1'b0;
  logic        ALE, RD_N, WR_N, IO_OR_M, DT_OR_R, DEN_N, INTA_N, busy;

  int n_checks = 0;
  int n_fail   = 0;
  int rsp_cnt  = 0;
  int cyc      = 0;

  bus_cycle_initiator #(.MAX_WAIT_STATES(4), .INTA_IDLE_STATES(2)) dut (
    .clock(clock), .reset_n(reset_n),
    .cpu_clock_posedge(cpu_clock_posedge), .cpu_clock_negedge(cpu_clock_negedge),
    .req_valid(req_valid), .req_ready(req_ready), .req_type(req_type),
    .req_address(req_address), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_error(rsp_error),
    .ADDRESS(ADDRESS), .DATA_OUT(DATA_OUT), .DATA_IN(DATA_IN), .RDY(RDY),
    .ALE(ALE), .RD_N(RD_N), .WR_N(WR_N), .IO_OR_M(IO_OR_M), .DT_OR_R(DT_OR_R),
    .DEN_N(DEN_N), .INTA_N(INTA_N), .busy(busy)
  );

  always #5 clock = ~clock;

  // One T-state every 4 clocks: negedge enable on phase 1, posedge on phase 3.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      cyc = cyc + 1;
      cpu_clock_posedge = (cyc % 4 == 3);
      cpu_clock_negedge = (cyc % 4 == 1);
    end
  end

  // Count response pulses independently of the transaction driver.
  initial begin
    forever begin
      @(negedge clock);
      if (rsp_valid) rsp_cnt = rsp_cnt + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance to just after the next clock edge that carries cpu_clock_posedge.
  task automatic step_t();
    bit was;
    was = 1'b0;
    while (!was) begin
      @(posedge clock);
      was = cpu_clock_posedge;
      #2;
    end
  endtask

  typedef struct {
    logic [2:0]  typ;
    logic [19:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  din;
    int          waits;     // T-states with RDY low from T3 on (99 = stuck)
    int          e_len;     // T-state index (T1 = 0) at which rsp_valid shows
    int          e_ale;
    int          e_rd;
    int          e_wr;
    int          e_inta;
    logic        e_io;
    logic        e_dtr;
    logic [19:0] e_addr;
    logic [7:0]  e_dout;
    bit          chk_data;
    logic [7:0]  e_data;
    logic        e_err;
  } vec_t;

  vec_t vecs[8];

  task automatic run_txn(input vec_t v, input int n);
    int idx, ale_c, rd_c, wr_c, inta_c, viol, rsp0;
    logic io_s, dtr_s;
    logic [19:0] addr_s;
    logic [7:0] dout_s, rdata;
    logic rerr;
    bit done;
    idx = 0; ale_c = 0; rd_c = 0; wr_c = 0; inta_c = 0; viol = 0;
    io_s = 1'b0; dtr_s = 1'b0; addr_s = '0; dout_s = '0; rdata = '0; rerr = 1'b0;
    done = 1'b0;
    rsp0 = rsp_cnt;
    req_type = v.typ; req_address = v.addr; req_data = v.wdata;
    DATA_IN = v.din; RDY = 1'b0; req_valid = 1'b1;
    step_t();
    req_valid = 1'b0;
    while (!done && idx < 40) begin
      if (ALE) begin
        ale_c = ale_c + 1; addr_s = ADDRESS; io_s = IO_OR_M; dtr_s = DT_OR_R;
      end
      if (!RD_N) rd_c = rd_c + 1;
      if (!WR_N) wr_c = wr_c + 1;
      if (!INTA_N) inta_c = inta_c + 1;
      if (int'(!RD_N) + int'(!WR_N) + int'(!INTA_N) > 1) viol = viol + 1;
      if (DATA_OUT != 8'h00) dout_s = DATA_OUT;
      if (rsp_valid) begin
        done = 1'b1; rdata = rsp_data; rerr = rsp_error;
      end else begin
        RDY = (idx >= 2 + v.waits);
        // Junk on the bus during INTA1 must not reach the response.
        if (v.typ == 3'(INTA)) DATA_IN = (idx < 4) ? 8'hC3 : v.din;
        idx = idx + 1;
        step_t();
      end
    end
    $display("txn %0d type=%0d addr=%05h len=%0d ale=%0d rd=%0d wr=%0d inta=%0d rsp_data=%02h err=%0b",
             n, v.typ, v.addr, idx, ale_c, rd_c, wr_c, inta_c, rdata, rerr);
    chk($sformatf("v%0d rsp_seen", n), done, 1);
    chk($sformatf("v%0d length", n), idx, v.e_len);
    chk($sformatf("v%0d ale_pulses", n), ale_c, v.e_ale);
    chk($sformatf("v%0d rd_low", n), rd_c, v.e_rd);
    chk($sformatf("v%0d wr_low", n), wr_c, v.e_wr);
    chk($sformatf("v%0d inta_low", n), inta_c, v.e_inta);
    chk($sformatf("v%0d strobe_overlap", n), viol, 0);
    chk($sformatf("v%0d io_or_m", n), io_s, v.e_io);
    chk($sformatf("v%0d dt_or_r", n), dtr_s, v.e_dtr);
    chk($sformatf("v%0d address", n), addr_s, v.e_addr);
    chk($sformatf("v%0d data_out", n), dout_s, v.e_dout);
    chk($sformatf("v%0d rsp_error", n), rerr, v.e_err);
    if (v.chk_data) chk($sformatf("v%0d rsp_data", n), rdata, v.e_data);
    step_t();
    chk($sformatf("v%0d idle_busy", n), busy, 0);
    chk($sformatf("v%0d idle_address", n), ADDRESS, 0);
    chk($sformatf("v%0d idle_io_or_m", n), IO_OR_M, 0);
    chk($sformatf("v%0d idle_dt_or_r", n), DT_OR_R, 1);
    chk($sformatf("v%0d rsp_pulses", n), rsp_cnt - rsp0, 1);
  endtask

  initial begin
    int rsp0;
    bit rdy_seen;
    //         typ     addr      wd     din    w   len ale rd wr in io dtr e_addr    dout  cd  data   err
    vecs[0] = '{MEM_RD, 20'hF0000, 8'h00, 8'h5A, 0,  3, 1, 2, 0, 0, 0, 0, 20'hF0000, 8'h00, 1, 8'h5A, 0};
    vecs[1] = '{IO_WR,  20'h00021, 8'hFE, 8'h00, 0,  3, 1, 0, 2, 0, 1, 1, 20'h00021, 8'hFE, 0, 8'h00, 0};
    vecs[2] = '{MEM_RD, 20'h3C000, 8'h00, 8'hA5, 3,  6, 1, 5, 0, 0, 0, 0, 20'h3C000, 8'h00, 1, 8'hA5, 0};
    vecs[3] = '{IO_RD,  20'h1F3F8, 8'h00, 8'h77, 1,  4, 1, 3, 0, 0, 1, 0, 20'h0F3F8, 8'h00, 1, 8'h77, 0};
    vecs[4] = '{MEM_WR, 20'h12345, 8'h33, 8'h00, 2,  5, 1, 0, 4, 0, 0, 1, 20'h12345, 8'h33, 0, 8'h00, 0};
    vecs[5] = '{INTA,   20'h00000, 8'h00, 8'h08, 0,  9, 2, 0, 0, 4, 1, 0, 20'h00000, 8'h00, 1, 8'h08, 0};
    vecs[6] = '{MEM_RD, 20'h00400, 8'h00, 8'h11, 99, 7, 1, 6, 0, 0, 0, 0, 20'h00400, 8'h00, 1, 8'hFF, 1};
    vecs[7] = '{INTA,   20'h00000, 8'h00, 8'h08, 99, 7, 1, 0, 0, 6, 1, 0, 20'h00000, 8'h00, 1, 8'hFF, 1};

    // Reset state, with a request pending to show it is not accepted.
    reset_n = 1'b0;
    req_valid = 1'b1;
    repeat (8) @(posedge clock);
    #2;
    chk("rst ALE", ALE, 0);
    chk("rst RD_N", RD_N, 1);
    chk("rst WR_N", WR_N, 1);
    chk("rst INTA_N", INTA_N, 1);
    chk("rst DEN_N", DEN_N, 1);
    chk("rst IO_OR_M", IO_OR_M, 0);
    chk("rst DT_OR_R", DT_OR_R, 1);
    chk("rst ADDRESS", ADDRESS, 0);
    chk("rst DATA_OUT", DATA_OUT, 0);
    chk("rst rsp_valid", rsp_valid, 0);
    chk("rst rsp_error", rsp_error, 0);
    chk("rst rsp_data", rsp_data, 0);
    chk("rst busy", busy, 0);
    chk("rst req_ready", req_ready, 0);
    req_valid = 1'b0;
    reset_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_txn(vecs[i], i);
    end

    // Reset in T2 of a write: strobes drop on that clock, no response.
    rsp0 = rsp_cnt;
    req_type = 3'(MEM_WR); req_address = 20'hABCDE; req_data = 8'h5C;
    RDY = 1'b1; req_valid = 1'b1;
    step_t();
    req_valid = 1'b0;
    @(posedge clock);
    #2;
    chk("hold ALE off-edge", ALE, 1);
    step_t();
    chk("midrst WR_N in T2", WR_N, 0);
    chk("midrst DEN_N in T2", DEN_N, 0);
    chk("midrst DATA_OUT in T2", DATA_OUT, 8'h5C);
    reset_n = 1'b0;
    @(posedge clock);
    #2;
    chk("midrst WR_N", WR_N, 1);
    chk("midrst DEN_N", DEN_N, 1);
    chk("midrst DATA_OUT", DATA_OUT, 0);
    chk("midrst busy", busy, 0);
    repeat (4) @(posedge clock);
    #2;
    chk("midrst req_ready held", req_ready, 0);
    reset_n = 1'b1;
    rdy_seen = 1'b0;
    for (int k = 0; k < 12 && !rdy_seen; k++) begin
      @(posedge clock);
      #2;
      if (req_ready) rdy_seen = 1'b1;
    end
    chk("midrst req_ready after release", rdy_seen, 1);
    chk("midrst no rsp", rsp_cnt - rsp0, 0);
    $display("txn reset-in-write addr=%05h rsp_pulses=%0d", 20'hABCDE, rsp_cnt - rsp0);

    run_txn(vecs[0], 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard stop in case a wait is ever left unbounded.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
